ide_disk_model: RTL

//  Synthesizable ATA PIO device model for the tss8 IDE path: task-file registers, READ SECTORS (0x20),

---
 rtl/ide_disk_model_if.sv | 21 ++
 rtl/ide_disk_model.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ide_disk_model_if.sv
// Host-side ATA PIO pin bundle between an IDE host and the disk model.
`timescale 1ns/1ps
interface ide_disk_model_if;
  logic        ide_dior_n;
  logic        ide_diow_n;
  logic [1:0]  ide_cs_n;
  logic [2:0]  ide_da;
  logic [15:0] ide_data_in;
  logic [15:0] ide_data_out;
  logic        ide_data_oe;

  modport master (
    output ide_dior_n, ide_diow_n, ide_cs_n, ide_da, ide_data_in,
    input  ide_data_out, ide_data_oe
  );

  modport slave (
    input  ide_dior_n, ide_diow_n, ide_cs_n, ide_da, ide_data_in,
    output ide_data_out, ide_data_oe
  );
endinterface

// File: rtl/ide_disk_model.sv
// ATA PIO device model: task file, READ/WRITE SECTORS with multi-sector transfers, BSY timing,
// abort on unknown commands, soft reset, and a small on-chip sector store.
`timescale 1ns/1ps
module ide_disk_model #(
  parameter int DISK_SECTORS = 16,
  parameter int SECTOR_WORDS = 256,
  parameter int BUSY_CYCLES  = 8
) (
  input  logic clk,
  input  logic reset_n,
  ide_disk_model_if.slave bus
);
  localparam int SB = $clog2(DISK_SECTORS);
  localparam int WB = $clog2(SECTOR_WORDS);
  localparam int CB = $clog2(BUSY_CYCLES + 1);
  localparam logic [CB-1:0] BUSY_LOAD = CB'(BUSY_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_BUSY, S_XFER_RD, S_XFER_WR, S_SRST} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_dior_d1, r_dior_d2, r_diow_d1, r_diow_d2;
  logic [1:0]    r_cs_n;
  logic [2:0]    r_da;
  logic [15:0]   r_din;
  logic [CB-1:0] r_busy_cnt;
  logic          r_is_wr, r_err;
  logic [7:0]    r_count;
  logic [27:0]   r_lba;
  logic [3:0]    r_dh_hi;
  logic [WB-1:0] r_idx;
  logic [15:0]   r_data_out;
  logic          r_data_oe;
  logic [15:0]   r_mem [DISK_SECTORS*SECTOR_WORDS];

  logic          w_rd_fire, w_wr_fire, w_cmd_blk, w_ctl_blk, w_busy;
  logic          w_data_rd, w_data_wr, w_adv, w_last;
  logic          w_cmd_wr, w_cmd_ok, w_cmd_bad, w_tf_wr, w_devctl, w_srst_set, w_srst_clr;
  logic [SB+WB-1:0] w_mem_addr;
  logic [15:0]   w_mem_rd, w_rd_mux;
  logic [7:0]    w_status;

  // An access completes on the low->high edge of the registered strobe.
  assign w_rd_fire  = r_dior_d1 & ~r_dior_d2;
  assign w_wr_fire  = r_diow_d1 & ~r_diow_d2;
  assign w_cmd_blk  = (r_cs_n == 2'b10);
  assign w_ctl_blk  = (r_cs_n == 2'b01);
  assign w_busy     = (r_state == S_BUSY) || (r_state == S_SRST);
  assign w_data_rd  = w_rd_fire & w_cmd_blk & (r_da == 3'd0);
  assign w_data_wr  = w_wr_fire & w_cmd_blk & (r_da == 3'd0);
  assign w_adv      = ((r_state == S_XFER_RD) & w_data_rd) | ((r_state == S_XFER_WR) & w_data_wr);
  assign w_last     = &r_idx;
  assign w_cmd_wr   = w_wr_fire & w_cmd_blk & (r_da == 3'd7) & (r_state == S_IDLE);
  assign w_cmd_ok   = w_cmd_wr & ((r_din[7:0] == 8'h20) | (r_din[7:0] == 8'h30));
  assign w_cmd_bad  = w_cmd_wr & ~w_cmd_ok;
  assign w_tf_wr    = w_wr_fire & w_cmd_blk & (r_da >= 3'd2) & (r_da <= 3'd6) & ~w_busy;
  assign w_devctl   = w_wr_fire & w_ctl_blk & (r_da == 3'd6);
  assign w_srst_set = w_devctl & r_din[2];
  assign w_srst_clr = w_devctl & ~r_din[2] & (r_state == S_SRST);
  assign w_mem_addr = {r_lba[SB-1:0], r_idx};
  assign w_mem_rd   = r_mem[w_mem_addr];

  always_comb begin
    w_status = {7'h28, r_err};
    if (w_busy) w_status = 8'hD0;
    else if (r_state == S_XFER_RD || r_state == S_XFER_WR) w_status = 8'h58;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_cmd_ok) w_state_nxt = S_BUSY;
      S_BUSY:    if (r_busy_cnt == '0) w_state_nxt = r_is_wr ? S_XFER_WR : S_XFER_RD;
      S_XFER_RD,
      S_XFER_WR: if (w_adv && w_last) w_state_nxt = (r_count == 8'd1) ? S_IDLE : S_BUSY;
      default:   w_state_nxt = r_state;
    endcase
    if (w_srst_set)      w_state_nxt = S_SRST;
    else if (w_srst_clr) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dior_d1 <= 1'b1;  r_dior_d2 <= 1'b1;
      r_diow_d1 <= 1'b1;  r_diow_d2 <= 1'b1;
      r_cs_n    <= 2'b11; r_da      <= '0;   r_din   <= '0;
    end else begin
      r_dior_d1 <= bus.ide_dior_n; r_dior_d2 <= r_dior_d1;
      r_diow_d1 <= bus.ide_diow_n; r_diow_d2 <= r_diow_d1;
      r_cs_n    <= bus.ide_cs_n;   r_da      <= bus.ide_da; r_din <= bus.ide_data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy_cnt <= '0;  r_is_wr <= 1'b0;   r_err <= 1'b0;
      r_count    <= 8'd1; r_lba  <= '0;     r_dh_hi <= 4'hE; r_idx <= '0;
    end else if (w_srst_clr) begin
      r_busy_cnt <= '0;  r_is_wr <= 1'b0;   r_err <= 1'b0;
      r_count    <= 8'd1; r_lba  <= '0;     r_dh_hi <= 4'hE; r_idx <= '0;
    end else begin
      if (r_state == S_BUSY && r_busy_cnt != '0) r_busy_cnt <= r_busy_cnt - 1'b1;
      if (w_tf_wr) begin
        case (r_da)
          3'd2:    r_count      <= r_din[7:0];
          3'd3:    r_lba[7:0]   <= r_din[7:0];
          3'd4:    r_lba[15:8]  <= r_din[7:0];
          3'd5:    r_lba[23:16] <= r_din[7:0];
          default: begin r_dh_hi <= r_din[7:4]; r_lba[27:24] <= r_din[3:0]; end
        endcase
      end
      if (w_cmd_ok) begin
        r_is_wr    <= (r_din[7:0] == 8'h30);
        r_err      <= 1'b0;
        r_busy_cnt <= BUSY_LOAD;
      end
      if (w_cmd_bad) r_err <= 1'b1;
      if (w_adv) begin
        if (w_last) begin
          r_idx      <= '0;
          r_lba      <= r_lba + 28'd1;
          r_count    <= r_count - 8'd1;
          r_busy_cnt <= BUSY_LOAD;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_adv && r_state == S_XFER_WR) r_mem[w_mem_addr] <= r_din;
  end

  // Read source follows the live address pins so the word is ready before the strobe ends.
  always_comb begin
    w_rd_mux = '0;
    if (bus.ide_cs_n == 2'b10) begin
      case (bus.ide_da)
        3'd0:    w_rd_mux = (r_state == S_XFER_RD) ? w_mem_rd : 16'h0;
        3'd1:    w_rd_mux = {13'h0, r_err, 2'b00};
        3'd2:    w_rd_mux = {8'h0, r_count};
        3'd3:    w_rd_mux = {8'h0, r_lba[7:0]};
        3'd4:    w_rd_mux = {8'h0, r_lba[15:8]};
        3'd5:    w_rd_mux = {8'h0, r_lba[23:16]};
        3'd6:    w_rd_mux = {8'h0, r_dh_hi, r_lba[27:24]};
        default: w_rd_mux = {8'h0, w_status};
      endcase
    end else if (bus.ide_cs_n == 2'b01 && bus.ide_da == 3'd6) begin
      w_rd_mux = {8'h0, w_status};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= '0;
      r_data_oe  <= 1'b0;
    end else begin
      r_data_out <= w_rd_mux;
      r_data_oe  <= ~bus.ide_dior_n & (bus.ide_cs_n != 2'b11);
    end
  end

  assign bus.ide_data_out = r_data_out;
  assign bus.ide_data_oe  = r_data_oe;
endmodule
